control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/reg_file.sv | 39 +++
 rtl/control_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, instruction field layout, opcodes and FSM states for the
// 4-bit-address, 16-bit-data control unit.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned REG_N  = 8;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned IMM_W  = 8;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS_MSB  = 8;
  localparam int unsigned RS_LSB  = 6;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXECUTE  = 3'd2,
    ST_OUT_WAIT = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [IMM_W-1:0]  imm;
  } decoded_t;

  // rs and imm overlap in bits [7:6]; each opcode uses only one of them.
  function automatic decoded_t decode(input logic [DATA_W-1:0] inst);
    decoded_t d;
    d.op  = inst[OP_MSB:OP_LSB];
    d.rd  = inst[RD_MSB:RD_LSB];
    d.rs  = inst[RS_MSB:RS_LSB];
    d.imm = inst[IMM_MSB:IMM_LSB];
    return d;
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Eight 16-bit registers: two combinational read ports, one synchronous write
// port, r0 hardwired to zero.
module reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_regs [REG_N];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      for (int i = 1; i < REG_N; i++) begin
        if (i_waddr == REG_AW'(i)) begin
          r_regs[i] <= i_wdata;
        end
      end
    end
  end

  always_comb begin
    o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
    o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/execute controller with a valid/ready output channel
// and a sticky halt state.
module control_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

  state_e            r_state;
  state_e            w_state_d;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_d;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] w_ir_d;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] w_out_data_d;
  logic              r_out_valid;
  logic              w_out_valid_d;
  logic              r_halted;
  logic              w_halted_d;

  decoded_t          w_dec;
  logic [DATA_W-1:0] w_rd_val;
  logic [DATA_W-1:0] w_rs_val;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_dec    = decode(r_ir);
  assign w_pc_inc = r_pc + ADDR_W'(1);

  reg_file u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raddr_a (w_dec.rd),
    .i_raddr_b (w_dec.rs),
    .o_rdata_a (w_rd_val),
    .o_rdata_b (w_rs_val),
    .i_we      (w_we),
    .i_waddr   (w_dec.rd),
    .i_wdata   (w_wdata)
  );

  // Arithmetic result for the instruction held in IR; wraps modulo 2^16.
  always_comb begin
    w_wdata = '0;
    case (w_dec.op)
      OP_ADDI: w_wdata = w_rd_val + {{(DATA_W - IMM_W){1'b0}}, w_dec.imm};
      OP_ADD:  w_wdata = w_rd_val + w_rs_val;
      OP_SUB:  w_wdata = w_rd_val - w_rs_val;
      default: w_wdata = '0;
    endcase
  end

  always_comb begin
    w_state_d     = r_state;
    w_pc_d        = r_pc;
    w_ir_d        = r_ir;
    w_out_data_d  = r_out_data;
    w_out_valid_d = r_out_valid;
    w_halted_d    = r_halted;
    w_we          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        w_ir_d    = instruction;
        w_state_d = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        if (w_dec.op == OP_OUT) begin
          w_out_data_d  = w_rd_val;
          w_out_valid_d = 1'b1;
          w_state_d     = ST_OUT_WAIT;
        end else if (w_dec.op == OP_HALT) begin
          w_halted_d = 1'b1;
          w_state_d  = ST_HALT;
        end else begin
          w_we      = writes_rd(w_dec.op);
          w_pc_d    = (w_dec.op == OP_JMP) ? w_dec.imm[ADDR_W-1:0] : w_pc_inc;
          w_state_d = run ? ST_FETCH : ST_IDLE;
        end
      end

      ST_OUT_WAIT: begin
        if (out_ready) begin
          w_out_valid_d = 1'b0;
          w_pc_d        = w_pc_inc;
          w_state_d     = run ? ST_FETCH : ST_IDLE;
        end
      end

      ST_HALT: begin
        w_state_d = ST_HALT;
      end

      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_ir        <= w_ir_d;
      r_out_data  <= w_out_data_d;
      r_out_valid <= w_out_valid_d;
      r_halted    <= w_halted_d;
    end
  end

  assign inst_addr = r_pc;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign halted    = r_halted;

endmodule
